// File: rtl/eth_frame_generator.sv
// Ethernet II frame builder for a 100 Mb/s RMII transmitter, one dibit per clk.
// Optional padding to the 46-byte minimum payload is enabled by `ETH_FRAME_GEN_PAD_EN.
module eth_frame_generator #(
    parameter logic [47:0] DEST_MAC  = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC   = 48'h02_00_00_00_00_01,
    parameter logic [15:0] ETHERTYPE = 16'h88B5,
    parameter int          MAX_LEN   = 1500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [10:0] len,
    output logic        readclk,
    input  logic        inclk,
    input  logic [7:0]  in,
    output logic        txen,
    output logic [1:0]  txd,
    output logic        ready,
    output logic        done,
    output logic        err
);

    localparam logic [111:0] HDR        = {DEST_MAC, SRC_MAC, ETHERTYPE};
    localparam logic [31:0]  POLY       = 32'hEDB8_8320;
    localparam logic [10:0]  MAX_LEN_W  = 11'(MAX_LEN);
    localparam logic [10:0]  IPG_LAST   = 11'd47;

`ifdef ETH_FRAME_GEN_PAD_EN
    typedef enum logic [2:0] {
        IDLE, PREAMBLE, SFD, HEADER, PAYLOAD, PAD, FCS, IPG
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, PREAMBLE, SFD, HEADER, PAYLOAD, FCS, IPG
    } state_t;
`endif

    state_t      state, state_n;
    logic [10:0] cnt, cnt_n;
    logic [1:0]  dib, dib_n;
    logic [7:0]  cur_byte, cur_byte_n;
    logic [10:0] len_q, len_q_n;
    logic [31:0] crc, crc_n;
    logic [7:0]  pf, pf_n;
    logic        pf_valid, pf_valid_n;
    logic        pending, pending_n;
    logic        txen_n, readclk_n, done_n, err_n, ready_n;
    logic [1:0]  txd_n;

    logic        load, fetch, after_pl;
    state_t      ld_state;
    logic [10:0] ld_cnt;
    logic [7:0]  ld_byte;
    logic [1:0]  nxt_dib;
    logic [31:0] fcs_word;

    assign fcs_word = ~crc;

    function automatic logic [7:0] hdr_byte(input logic [10:0] i);
        return HDR[8*(13 - int'(i)) +: 8];
    endfunction

    // Reflected CRC-32, bit 0 of the dibit enters first as it does on the wire
    function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 2; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ POLY) : (r >> 1);
        end
        return r;
    endfunction

    function automatic logic is_data(input state_t s);
`ifdef ETH_FRAME_GEN_PAD_EN
        return (s == HEADER) || (s == PAYLOAD) || (s == PAD);
`else
        return (s == HEADER) || (s == PAYLOAD);
`endif
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            dib      <= '0;
            cur_byte <= '0;
            len_q    <= '0;
            crc      <= '1;
            pf       <= '0;
            pf_valid <= 1'b0;
            pending  <= 1'b0;
            txen     <= 1'b0;
            txd      <= 2'b00;
            readclk  <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            ready    <= 1'b1;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            dib      <= dib_n;
            cur_byte <= cur_byte_n;
            len_q    <= len_q_n;
            crc      <= crc_n;
            pf       <= pf_n;
            pf_valid <= pf_valid_n;
            pending  <= pending_n;
            txen     <= txen_n;
            txd      <= txd_n;
            readclk  <= readclk_n;
            done     <= done_n;
            err      <= err_n;
            ready    <= ready_n;
        end
    end

    // Every output register is loaded with the value for the coming cycle
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        dib_n      = dib;
        cur_byte_n = cur_byte;
        len_q_n    = len_q;
        crc_n      = crc;
        pf_n       = pf;
        pf_valid_n = pf_valid;
        pending_n  = pending;
        txen_n     = 1'b0;
        txd_n      = 2'b00;
        readclk_n  = 1'b0;
        done_n     = 1'b0;
        err_n      = 1'b0;
        ready_n    = 1'b0;
        load       = 1'b0;
        fetch      = 1'b0;
        after_pl   = 1'b0;
        ld_state   = state;
        ld_cnt     = '0;
        ld_byte    = '0;
        nxt_dib    = dib + 2'd1;

        if (pending && inclk) begin
            pf_n       = in;
            pf_valid_n = 1'b1;
            pending_n  = 1'b0;
        end

        case (state)
            IDLE: begin
                ready_n = 1'b1;
                if (start) begin
                    state_n    = PREAMBLE;
                    cnt_n      = '0;
                    dib_n      = '0;
                    cur_byte_n = 8'h55;
                    len_q_n    = (len > MAX_LEN_W) ? MAX_LEN_W : len;
                    crc_n      = '1;
                    pf_valid_n = 1'b0;
                    pending_n  = 1'b0;
                    txen_n     = 1'b1;
                    txd_n      = 2'b01;
                    ready_n    = 1'b0;
                end
            end
            IPG: begin
                if (cnt == IPG_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    ready_n = 1'b1;
                end else begin
                    cnt_n = cnt + 11'd1;
                end
            end
            default: begin
                if (dib != 2'd3) begin
                    dib_n  = nxt_dib;
                    txen_n = 1'b1;
                    txd_n  = cur_byte[{nxt_dib, 1'b0} +: 2];
                    if (is_data(state)) crc_n = crc_dibit(crc, txd_n);
                end else begin
                    case (state)
                        PREAMBLE: begin
                            load = 1'b1;
                            if (cnt == 11'd6) begin
                                ld_state = SFD;
                                ld_byte  = 8'hD5;
                            end else begin
                                ld_state = PREAMBLE;
                                ld_cnt   = cnt + 11'd1;
                                ld_byte  = 8'h55;
                            end
                        end
                        SFD: begin
                            load     = 1'b1;
                            ld_state = HEADER;
                            ld_byte  = hdr_byte(11'd0);
                        end
                        HEADER: begin
                            if (cnt == 11'd13) begin
                                if (len_q == 11'd0) after_pl = 1'b1;
                                else                fetch    = 1'b1;
                            end else begin
                                load     = 1'b1;
                                ld_state = HEADER;
                                ld_cnt   = cnt + 11'd1;
                                ld_byte  = hdr_byte(ld_cnt);
                            end
                        end
                        PAYLOAD: begin
                            if (cnt == len_q - 11'd1) begin
                                after_pl = 1'b1;
                            end else begin
                                fetch  = 1'b1;
                                ld_cnt = cnt + 11'd1;
                            end
                        end
`ifdef ETH_FRAME_GEN_PAD_EN
                        PAD: begin
                            load = 1'b1;
                            if (cnt + len_q == 11'd45) begin
                                ld_state = FCS;
                                ld_byte  = fcs_word[7:0];
                            end else begin
                                ld_state = PAD;
                                ld_cnt   = cnt + 11'd1;
                            end
                        end
`endif
                        FCS: begin
                            if (cnt == 11'd3) begin
                                state_n = IPG;
                                cnt_n   = '0;
                                done_n  = 1'b1;
                            end else begin
                                load     = 1'b1;
                                ld_state = FCS;
                                ld_cnt   = cnt + 11'd1;
                                ld_byte  = fcs_word[{ld_cnt[1:0], 3'b000} +: 8];
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase

        if (after_pl) begin
            load   = 1'b1;
            ld_cnt = '0;
`ifdef ETH_FRAME_GEN_PAD_EN
            if (len_q < 11'd46) begin
                ld_state = PAD;
                ld_byte  = 8'h00;
            end else begin
                ld_state = FCS;
                ld_byte  = fcs_word[7:0];
            end
`else
            ld_state = FCS;
            ld_byte  = fcs_word[7:0];
`endif
        end

        // A byte arriving on the very edge it is due bypasses the prefetch register
        if (fetch) begin
            if (pf_valid) begin
                load       = 1'b1;
                ld_state   = PAYLOAD;
                ld_byte    = pf;
                pf_valid_n = 1'b0;
            end else if (pending && inclk) begin
                load       = 1'b1;
                ld_state   = PAYLOAD;
                ld_byte    = in;
                pf_valid_n = 1'b0;
                pending_n  = 1'b0;
            end else begin
                state_n    = IPG;
                cnt_n      = '0;
                err_n      = 1'b1;
                pending_n  = 1'b0;
                pf_valid_n = 1'b0;
            end
        end

        if (load) begin
            state_n    = ld_state;
            cnt_n      = ld_cnt;
            dib_n      = '0;
            cur_byte_n = ld_byte;
            txen_n     = 1'b1;
            txd_n      = ld_byte[1:0];
            if (is_data(ld_state)) crc_n = crc_dibit(crc, ld_byte[1:0]);
            if ((ld_state == HEADER && ld_cnt == 11'd13 && len_q != 11'd0) ||
                (ld_state == PAYLOAD && (ld_cnt + 11'd1) < len_q)) begin
                readclk_n = 1'b1;
                pending_n = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_eth_frame_generator.sv
// Randomized self-checking bench for eth_frame_generator against a byte-level frame model.
// Honors `ETH_FRAME_GEN_PAD_EN the same way as the design.
module tb_eth_frame_generator;

    localparam logic [47:0] DEST = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] SRC  = 48'h02_00_00_00_00_01;
    localparam logic [15:0] ETYP = 16'h88B5;
    localparam int          MAXL = 1500;
    localparam int          IPGC = 48;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [10:0] len = '0;
    logic        inclk = 1'b0;
    logic [7:0]  in = '0;
    logic        readclk, txen, ready, done, err;
    logic [1:0]  txd;

    eth_frame_generator dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .readclk(readclk), .inclk(inclk), .in(in),
        .txen(txen), .txd(txd), .ready(ready), .done(done), .err(err)
    );

    always #10 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int         accept_q[$], rise_q[$], fall_q[$], done_q[$], err_q[$], ready_q[$];
    logic [1:0] dib_q[$];
    int         rd_cnt = 0;
    logic       txen_d = 1'b0, ready_d = 1'b1;

    logic [7:0] pay_q[$];
    logic [7:0] exp_q[$];
    int         exp_p;
    int         resp_idx = 0, resp_cnt = 0, resp_limit = 0, resp_served = 0;
    bit         stray_en = 1'b0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Wire monitor: records event cycles mid-cycle, away from the clock edge
    initial forever begin
        @(negedge clk);
        cyc++;
        if (start && ready) accept_q.push_back(cyc);
        if (txen && !txen_d) rise_q.push_back(cyc);
        if (!txen && txen_d) fall_q.push_back(cyc);
        if (txen) dib_q.push_back(txd);
        if (done) done_q.push_back(cyc);
        if (err) err_q.push_back(cyc);
        if (ready && !ready_d) ready_q.push_back(cyc);
        if (readclk) rd_cnt++;
        txen_d  = txen;
        ready_d = ready;
    end

    // Upstream model: answers each request 1..3 cycles later, optionally injects stray strobes
    initial forever begin
        @(negedge clk);
        inclk = 1'b0;
        in    = 8'($urandom);
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                inclk = 1'b1;
                in    = (resp_idx < pay_q.size()) ? pay_q[resp_idx] : 8'h00;
                resp_idx++;
            end
        end else if (stray_en && !readclk && $urandom_range(7) == 0) begin
            inclk = 1'b1;
            in    = 8'hEE;
        end
        if (readclk && resp_served < resp_limit) begin
            resp_cnt = $urandom_range(3, 1);
            resp_served++;
        end
    end

    task automatic clear_mon();
        accept_q.delete(); rise_q.delete(); fall_q.delete();
        done_q.delete(); err_q.delete(); ready_q.delete();
        dib_q.delete();
        rd_cnt = 0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wait_ready", 64'(ready), 64'd1);
    endtask

    // Whole frame as a byte list: preamble, SFD, header, payload, pad, FCS low byte first
    task automatic build_expected(input int l);
        logic [7:0]  body[$];
        logic [31:0] c;
        int          p;
        exp_q.delete();
        for (int i = 0; i < 6; i++) body.push_back(DEST[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) body.push_back(SRC[47-8*i -: 8]);
        body.push_back(ETYP[15:8]);
        body.push_back(ETYP[7:0]);
        for (int i = 0; i < l; i++) body.push_back(pay_q[i]);
        p = l;
`ifdef ETH_FRAME_GEN_PAD_EN
        while (p < 46) begin
            body.push_back(8'h00);
            p++;
        end
`endif
        c = 32'hFFFF_FFFF;
        foreach (body[i]) begin
            c = c ^ {24'h0, body[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        c = ~c;
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        foreach (body[i]) exp_q.push_back(body[i]);
        for (int i = 0; i < 4; i++) exp_q.push_back(c[8*i +: 8]);
        exp_p = p;
    endtask

    task automatic check_bytes(input string tag, input int nbytes);
        int         mism;
        logic [7:0] rx;
        mism = 0;
        for (int i = 0; i < nbytes; i++) begin
            if (4*i + 3 < dib_q.size()) begin
                rx = {dib_q[4*i+3], dib_q[4*i+2], dib_q[4*i+1], dib_q[4*i]};
                if (rx !== exp_q[i]) mism++;
            end else begin
                mism++;
            end
        end
        checkOutput(tag, 64'(mism), 64'd0);
    endtask

    task automatic applyStimulus(input int l_req, input int limit, input bit ramp, input bit poke);
        int l_eff, n, acc, rise, fall, on, k, pre_ok;
        logic [31:0] fcs_rx, fcs_exp;
        l_eff = (l_req > MAXL) ? MAXL : l_req;
        pay_q.delete();
        for (int i = 0; i < l_eff; i++) pay_q.push_back(ramp ? 8'(i) : 8'($urandom));
        build_expected(l_eff);
        wait_ready();
        resp_idx = 0; resp_cnt = 0; resp_served = 0;
        resp_limit = limit;
        stray_en = (limit >= l_eff);
        clear_mon();
        len = 11'(l_req);
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        n = 0;
        while (ready_q.size() == 0 && n < 8000) begin
            @(posedge clk); #2;
            n++;
            if (poke && accept_q.size() > 0)
                start = (cyc == accept_q[0] + 120) || (fall_q.size() > 0 && cyc == fall_q[0] + 10);
        end
        start = 1'b0;
        checkOutput("frame_timeout", 64'(n < 8000), 64'd1);
        checkOutput("accepts", 64'(accept_q.size()), 64'd1);
        acc  = (accept_q.size() > 0) ? accept_q[0] : -1;
        rise = (rise_q.size() > 0) ? rise_q[0] : -1;
        fall = (fall_q.size() > 0) ? fall_q[0] : -1;
        checkOutput("txen_rise", 64'(rise), 64'(acc + 1));
        pre_ok = 1;
        for (int i = 0; i < 32; i++)
            if (i >= dib_q.size() || dib_q[i] !== ((i == 31) ? 2'b11 : 2'b01)) pre_ok = 0;
        checkOutput("preamble_sfd", 64'(pre_ok), 64'd1);
        if (limit < l_eff) begin
            k  = limit;
            on = 4 * (22 + k);
            checkOutput("underrun_err_cnt", 64'(err_q.size()), 64'd1);
            checkOutput("underrun_err_cyc", 64'((err_q.size() > 0) ? err_q[0] : -1), 64'(acc + 1 + on));
            checkOutput("underrun_no_done", 64'(done_q.size()), 64'd0);
            checkOutput("underrun_readclk", 64'(rd_cnt), 64'(k + 1));
            check_bytes("underrun_bytes", 22 + k);
        end else begin
            on = 4 * (26 + exp_p);
            checkOutput("done_cnt", 64'(done_q.size()), 64'd1);
            checkOutput("done_cyc", 64'((done_q.size() > 0) ? done_q[0] : -1), 64'(fall));
            checkOutput("no_err", 64'(err_q.size()), 64'd0);
            checkOutput("readclk_cnt", 64'(rd_cnt), 64'(l_eff));
            check_bytes("frame_bytes", 26 + exp_p);
            fcs_rx = '0;
            for (int i = 0; i < 16; i++)
                if (on - 16 + i >= 0 && on - 16 + i < dib_q.size()) fcs_rx[2*i +: 2] = dib_q[on - 16 + i];
            fcs_exp = {exp_q[exp_q.size()-1], exp_q[exp_q.size()-2], exp_q[exp_q.size()-3], exp_q[exp_q.size()-4]};
            checkOutput("fcs", 64'(fcs_rx), 64'(fcs_exp));
        end
        checkOutput("txen_len", 64'(fall - rise), 64'(on));
        checkOutput("ready_rise", 64'((ready_q.size() > 0) ? ready_q[0] - fall : -1), 64'(IPGC));
    endtask

    task automatic held_start_test();
        int n, on, p;
        pay_q.delete();
        for (int i = 0; i < 16; i++) pay_q.push_back(8'($urandom));
        wait_ready();
        resp_idx = 0; resp_cnt = 0; resp_served = 0;
        resp_limit = 100; stray_en = 1'b0;
        clear_mon();
        len = 11'd8;
        @(posedge clk); #2 start = 1'b1;
        n = 0;
        while (accept_q.size() < 2 && n < 2000) begin
            @(posedge clk); #2;
            n++;
        end
        start = 1'b0;
        while (ready_q.size() < 2 && n < 2000) begin
            @(posedge clk); #2;
            n++;
        end
        p = 8;
`ifdef ETH_FRAME_GEN_PAD_EN
        p = 46;
`endif
        on = 4 * (26 + p);
        checkOutput("held_timeout", 64'(n < 2000), 64'd1);
        checkOutput("held_gap", 64'((accept_q.size() > 1 && fall_q.size() > 0) ? accept_q[1] - fall_q[0] : -1), 64'(IPGC));
        checkOutput("held_len2", 64'((fall_q.size() > 1 && rise_q.size() > 1) ? fall_q[1] - rise_q[1] : -1), 64'(on));
        checkOutput("held_done", 64'(done_q.size()), 64'd2);
    endtask

    task automatic reset_mid_frame();
        int acc, n;
        pay_q.delete();
        for (int i = 0; i < 40; i++) pay_q.push_back(8'($urandom));
        wait_ready();
        resp_idx = 0; resp_cnt = 0; resp_served = 0;
        resp_limit = 40; stray_en = 1'b0;
        clear_mon();
        len = 11'd40;
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        acc = (accept_q.size() > 0) ? accept_q[0] : cyc;
        n = 0;
        while (cyc < acc + 168 && n < 400) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_dibits_before", 64'(dib_q.size()), 64'd169);
        checkOutput("rst_txen", 64'(txen), 64'd0);
        checkOutput("rst_ready", 64'(ready), 64'd1);
        repeat (60) @(negedge clk);
        checkOutput("rst_no_done", 64'(done_q.size()), 64'd0);
        checkOutput("rst_no_err", 64'(err_q.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_txen", 64'(txen), 64'd0);
        checkOutput("reset_txd", 64'(txd), 64'd0);
        checkOutput("reset_readclk", 64'(readclk), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_err", 64'(err), 64'd0);
        checkOutput("reset_ready", 64'(ready), 64'd1);

        applyStimulus(46, 46, 1'b1, 1'b0);
        applyStimulus(10, 10, 1'b0, 1'b0);
        applyStimulus(46, 0, 1'b0, 1'b0);
        applyStimulus(30, 12, 1'b0, 1'b0);
        applyStimulus(60, 60, 1'b0, 1'b1);
        applyStimulus(0, 0, 1'b0, 1'b0);
        applyStimulus(45, 45, 1'b0, 1'b0);
        applyStimulus(47, 47, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            int l;
            l = $urandom_range(120, 1);
            applyStimulus(l, l, 1'b0, 1'b0);
        end
        held_start_test();
        reset_mid_frame();
        applyStimulus(50, 50, 1'b0, 1'b0);
        applyStimulus(1600, 9999, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
